yin_sched: RTL and testbench



---
 rtl/yin_pkg.sv | 16 +
 rtl/sample_fifo.sv | 61 ++++++
 rtl/yin_sched.sv | 146 ++++++++++++++
 tb/tb_yin_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yin_pkg.sv
// Shared definitions for the YIN pitch-detection path and its wrappers.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package yin_pkg;

  localparam int YIN_WIDTH       = 16;    // audio sample width
  localparam int YIN_TAU_WIDTH   = 11;    // clog2 of the default lag range (2048)
  localparam int YIN_WINDOW_SIZE = 2048;  // samples per pitch window

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with full/empty/count.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle.
// Ports: push/push_dat write side; pop/head read side (head valid while !empty);
//        full, empty and count reflect occupancy after the last edge.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push is about to take.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is not reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/yin_sched.sv
// Rate-limits buffered audio samples into the YIN pitch detector and latches its lag results.
// Latency: sample pushed into an empty FIFO issues 2 cycles later; results appear 1 cycle after yin_valid_in.
// Backpressure: none upstream; a push into a full FIFO with no pop is dropped and flags overflow_out.
// Ports: sample_in/valid_in feed the FIFO; enable_in gates issue; clear_in clears overflow_out;
//        yin_sample_out/yin_valid_out drive the detector; yin_taumin_in/yin_valid_in return its lag;
//        tau_out/voiced_out/tau_valid_out hold the result; window_count_out, fill_out, overflow_out are status.
module yin_sched
  import yin_pkg::*;
#(
  parameter int WIDTH       = YIN_WIDTH,
  parameter int WINDOW_SIZE = YIN_WINDOW_SIZE,
  parameter int TAUMAX      = 2048,
  parameter int FIFO_DEPTH  = 16,
  parameter int MIN_GAP     = 1040,
  parameter int MIN_TAU     = 20
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [WIDTH-1:0]              sample_in,
  input  logic                          valid_in,
  input  logic                          enable_in,
  input  logic                          clear_in,
  output logic [WIDTH-1:0]              yin_sample_out,
  output logic                          yin_valid_out,
  input  logic [$clog2(TAUMAX)-1:0]     yin_taumin_in,
  input  logic                          yin_valid_in,
  output logic [$clog2(TAUMAX)-1:0]     tau_out,
  output logic                          voiced_out,
  output logic                          tau_valid_out,
  output logic [15:0]                   window_count_out,
  output logic [$clog2(FIFO_DEPTH):0]   fill_out,
  output logic                          overflow_out
);

  localparam int TW = $clog2(TAUMAX);
  localparam int IW = $clog2(WINDOW_SIZE);
  localparam int GW = $clog2(MIN_GAP) + 1;
  // The issue cycle plus GAP span MIN_GAP-1 cycles; the IDLE cycle that
  // re-checks the FIFO completes the MIN_GAP period, so GAP itself holds
  // MIN_GAP-2 cycles with the counter running 1..MIN_GAP-2.
  localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 2);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WINDOW_SIZE - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  state_t                        state_q, state_d;
  logic [GW-1:0]                 gap_cnt_q;
  logic [IW-1:0]                 idx_q;
  logic [WIDTH-1:0]              fifo_head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          pop;
  logic                          drop;
  logic                          voiced;

  assign pop    = (state_q == ISSUE);
  assign drop   = valid_in && fifo_full && !pop;
  assign voiced = (yin_taumin_in >= TW'(MIN_TAU)) && (yin_taumin_in != '0);

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (valid_in),
    .push_dat (sample_in),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fill_out)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // enable_in only gates leaving IDLE, so an issue and its gap always run to completion.
  always_comb begin
    state_d        = state_q;
    yin_valid_out  = 1'b0;
    yin_sample_out = '0;
    case (state_q)
      IDLE: begin
        if (enable_in && !fifo_empty) state_d = ISSUE;
      end
      ISSUE: begin
        yin_valid_out  = 1'b1;
        yin_sample_out = fifo_head;
        state_d        = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      gap_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      gap_cnt_q <= GAP_ONE;
    end else if (state_q == GAP) begin
      gap_cnt_q <= (gap_cnt_q == GAP_LAST) ? '0 : gap_cnt_q + GAP_ONE;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idx_q            <= '0;
      window_count_out <= '0;
    end else if (pop) begin
      if (idx_q == IDX_LAST) begin
        idx_q            <= '0;
        window_count_out <= window_count_out + 16'd1;
      end else begin
        idx_q <= idx_q + IDX_ONE;
      end
    end
  end

  // A drop in the same cycle as clear_in leaves the flag set.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)        overflow_out <= 1'b0;
    else if (drop)     overflow_out <= 1'b1;
    else if (clear_in) overflow_out <= 1'b0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tau_out       <= '0;
      voiced_out    <= 1'b0;
      tau_valid_out <= 1'b0;
    end else begin
      tau_valid_out <= yin_valid_in;
      if (yin_valid_in) begin
        voiced_out <= voiced;
        tau_out    <= voiced ? yin_taumin_in : '0;
      end
    end
  end

endmodule

// File: tb/tb_yin_sched.sv
module tb_yin_sched;

  localparam int W  = 16;
  localparam int TW = 11;
  localparam int FW = 5;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in;

  // Instance a: default parameters
  logic [W-1:0]  a_sample, a_ysample;
  logic          a_valid, a_enable, a_clear, a_yv, a_yvo, a_tv, a_voiced, a_ovf;
  logic [TW-1:0] a_taumin, a_tau;
  logic [15:0]   a_win;
  logic [FW-1:0] a_fill;

  // Instance b: short window and gap
  logic [W-1:0]  b_sample, b_ysample;
  logic          b_valid, b_enable, b_clear, b_yv, b_yvo, b_tv, b_voiced, b_ovf;
  logic [TW-1:0] b_taumin, b_tau;
  logic [15:0]   b_win;
  logic [FW-1:0] b_fill;

  yin_sched dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .sample_in(a_sample), .valid_in(a_valid),
    .enable_in(a_enable), .clear_in(a_clear), .yin_sample_out(a_ysample),
    .yin_valid_out(a_yvo), .yin_taumin_in(a_taumin), .yin_valid_in(a_yv),
    .tau_out(a_tau), .voiced_out(a_voiced), .tau_valid_out(a_tv),
    .window_count_out(a_win), .fill_out(a_fill), .overflow_out(a_ovf)
  );

  yin_sched #(.WINDOW_SIZE(8), .MIN_GAP(4)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .sample_in(b_sample), .valid_in(b_valid),
    .enable_in(b_enable), .clear_in(b_clear), .yin_sample_out(b_ysample),
    .yin_valid_out(b_yvo), .yin_taumin_in(b_taumin), .yin_valid_in(b_yv),
    .tau_out(b_tau), .voiced_out(b_voiced), .tau_valid_out(b_tv),
    .window_count_out(b_win), .fill_out(b_fill), .overflow_out(b_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Issue log per instance: cycle number, sample, and window count seen during the issue.
  int          a_iss_cyc[$];
  logic [15:0] a_iss_dat[$];
  int          b_iss_cyc[$];
  logic [15:0] b_iss_dat[$];
  logic [15:0] b_iss_win[$];

  always @(negedge clk_in) begin
    if (a_yvo) begin
      a_iss_cyc.push_back(cyc);
      a_iss_dat.push_back(a_ysample);
    end
    if (b_yvo) begin
      b_iss_cyc.push_back(cyc);
      b_iss_dat.push_back(b_ysample);
      b_iss_win.push_back(b_win);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic nsample();
    @(negedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 0; a_enable = 0; a_clear = 0; a_yv = 0; a_sample = '0; a_taumin = '0;
    rst_in = 1'b1;
    repeat (2) tick();
    rst_in = 1'b0;
  endtask

  // Waits until instance a has issued n samples since base, bounded by budget cycles.
  task automatic wait_a(input int base, input int n, input int budget, input string tag);
    int k = 0;
    while (a_iss_cyc.size() < base + n && k < budget) begin
      nsample();
      k++;
    end
    check_eq(tag, a_iss_cyc.size() - base, n);
  endtask

  int a_base, t, e, bad;
  int r_val [6] = '{100, 5, 20, 19, 0, 2047};
  int r_tau [6] = '{100, 0, 20, 0, 0, 2047};
  int r_vcd [6] = '{1, 0, 1, 0, 0, 1};

  initial begin
    b_valid = 0; b_enable = 0; b_clear = 0; b_yv = 0; b_sample = '0; b_taumin = '0;
    do_reset();
    rst_in = 1'b1;
    nsample();
    check_eq("rst_fill", a_fill, 0);
    check_eq("rst_ovf", a_ovf, 0);
    check_eq("rst_yvo", a_yvo, 0);
    check_eq("rst_ysample", a_ysample, 0);
    check_eq("rst_tau", {a_tv, a_voiced, a_tau}, 0);
    check_eq("rst_win", a_win, 0);
    tick();
    rst_in = 1'b0;

    // Window wrap on the short instance: 17 samples back to back.
    b_enable = 1;
    for (int i = 0; i < 17; i++) begin
      tick();
      b_valid = 1; b_sample = 16'(16'h0100 + i);
    end
    tick();
    b_valid = 0;
    begin
      int k = 0;
      while (b_iss_cyc.size() < 17 && k < 200) begin nsample(); k++; end
    end
    check_eq("win_issues", b_iss_cyc.size(), 17);
    if (b_iss_cyc.size() >= 17) begin
      check_eq("win_before_8th", b_iss_win[7], 0);
      check_eq("win_after_8th", b_iss_win[8], 1);
      check_eq("win_before_16th", b_iss_win[15], 1);
      check_eq("win_after_16th", b_iss_win[16], 2);
      check_eq("win_spacing", b_iss_cyc[1] - b_iss_cyc[0], 4);
      bad = 0;
      for (int i = 0; i < 17; i++) if (b_iss_dat[i] != 16'(16'h0100 + i)) bad++;
      check_eq("win_order", bad, 0);
    end
    nsample();
    check_eq("win_final", b_win, 2);
    check_eq("win_ovf", b_ovf, 0);
    b_enable = 0;

    // Single sample latency and fill.
    do_reset();
    a_base = a_iss_cyc.size();
    a_enable = 1;
    tick();
    a_valid = 1; a_sample = 16'h1234; t = cyc;
    tick();
    a_valid = 0;
    nsample();
    check_eq("single_fill1", a_fill, 1);
    check_eq("single_no_early", a_yvo, 0);
    wait_a(a_base, 1, 20, "single_issued");
    if (a_iss_cyc.size() > a_base) begin
      check_eq("single_latency", a_iss_cyc[a_base] - t, 2);
      check_eq("single_data", a_iss_dat[a_base], 16'h1234);
    end
    nsample();
    check_eq("single_fill0", a_fill, 0);

    // Burst of 20 into a 16-deep FIFO.
    do_reset();
    a_base = a_iss_cyc.size();
    a_enable = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      a_valid = 1; a_sample = 16'(16'hA000 + i);
    end
    tick();
    a_valid = 0;
    nsample();
    check_eq("burst_ovf", a_ovf, 1);
    check_eq("burst_fill", a_fill, 16);
    wait_a(a_base, 17, 17 * 1040 + 200, "burst_issues");
    repeat (1100) nsample();
    check_eq("burst_no_extra", a_iss_cyc.size() - a_base, 17);
    if (a_iss_cyc.size() - a_base >= 17) begin
      bad = 0;
      for (int i = 1; i < 17; i++)
        if (a_iss_cyc[a_base + i] - a_iss_cyc[a_base + i - 1] != 1040) bad++;
      check_eq("burst_spacing", bad, 0);
      bad = 0;
      for (int i = 0; i < 17; i++) if (a_iss_dat[a_base + i] != 16'(16'hA000 + i)) bad++;
      check_eq("burst_order", bad, 0);
    end
    check_eq("burst_fill_end", a_fill, 0);
    check_eq("burst_ovf_sticky", a_ovf, 1);
    tick(); a_clear = 1;
    tick(); a_clear = 0;
    nsample();
    check_eq("clear_ovf", a_ovf, 0);

    // Full FIFO: drop beats clear, then push coinciding with an issue pop.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick();
      a_valid = 1; a_sample = 16'(16'hB000 + i);
    end
    tick();
    a_valid = 0;
    nsample();
    check_eq("full_fill", a_fill, 16);
    check_eq("full_ovf0", a_ovf, 0);
    tick(); a_valid = 1; a_sample = 16'hBEEF; a_clear = 1;
    tick(); a_valid = 0; a_clear = 0;
    nsample();
    check_eq("drop_beats_clear", a_ovf, 1);
    tick(); a_clear = 1;
    tick(); a_clear = 0;
    nsample();
    check_eq("full_cleared", a_ovf, 0);
    tick(); a_enable = 1;
    tick(); a_valid = 1; a_sample = 16'hB0FF;
    nsample();
    check_eq("full_issue_vld", a_yvo, 1);
    check_eq("full_issue_dat", a_ysample, 16'hB000);
    tick(); a_valid = 0;
    nsample();
    check_eq("pushpop_fill", a_fill, 16);
    check_eq("pushpop_ovf", a_ovf, 0);

    // Result capture, back-to-back strobes including MIN_TAU boundaries.
    do_reset();
    for (int i = 0; i <= 6; i++) begin
      tick();
      if (i < 6) begin a_yv = 1; a_taumin = TW'(r_val[i]); end
      else a_yv = 0;
      nsample();
      if (i > 0) begin
        check_eq($sformatf("res%0d_vld", i - 1), a_tv, 1);
        check_eq($sformatf("res%0d_tau", i - 1), a_tau, r_tau[i - 1]);
        check_eq($sformatf("res%0d_voiced", i - 1), a_voiced, r_vcd[i - 1]);
      end
    end
    tick();
    nsample();
    check_eq("res_strobe_off", a_tv, 0);
    check_eq("res_hold", {a_voiced, a_tau}, {1'b1, 11'd2047});

    // Reset in the middle of GAP with samples queued.
    do_reset();
    a_base = a_iss_cyc.size();
    a_enable = 1;
    tick(); a_yv = 1; a_taumin = 11'd100;
    tick(); a_yv = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      a_valid = 1; a_sample = 16'(16'hC000 + i);
    end
    tick();
    a_valid = 0;
    wait_a(a_base, 1, 20, "gap_first_issue");
    repeat (300) nsample();
    check_eq("gap_fill_pre", a_fill, 5);
    check_eq("gap_tau_pre", a_tau, 100);
    #1 rst_in = 1'b1;
    #1;
    check_eq("arst_fill", a_fill, 0);
    check_eq("arst_ovf_yvo", {a_ovf, a_yvo}, 0);
    check_eq("arst_ysample", a_ysample, 0);
    check_eq("arst_tau", {a_tv, a_voiced, a_tau}, 0);
    check_eq("arst_win", a_win, 0);
    tick();
    rst_in = 1'b0;
    a_enable = 0;
    a_base = a_iss_cyc.size();
    tick(); a_valid = 1; a_sample = 16'hD000;
    tick(); a_sample = 16'hD001;
    tick(); a_valid = 0;
    repeat (50) nsample();
    check_eq("dis_no_issue", a_iss_cyc.size() - a_base, 0);
    check_eq("dis_fill", a_fill, 2);
    tick(); a_enable = 1; e = cyc;
    wait_a(a_base, 1, 10, "en_issue");
    if (a_iss_cyc.size() > a_base) begin
      check_eq("en_latency", a_iss_cyc[a_base] - e, 1);
      check_eq("en_data", a_iss_dat[a_base], 16'hD000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
